// File: rtl/sort_serializer.sv
// sort_serializer
// Takes a fully sorted parallel vector in a single cycle and streams it out
// one element per beat, lowest index first (or highest first with REVERSE=1).
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer keeps its payload stable
// while valid && !ready; ready never depends on the same port's valid. Here
// in_ready depends on out_ready only in the last-beat cycle, so a new vector
// can be taken while the final beat of the previous one leaves.
module sort_serializer #(
  parameter int VALUE_BITS = 32,
  parameter int DEPTH      = 8,
  parameter int REVERSE    = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [(1 << DEPTH)-1:0][VALUE_BITS-1:0]    in,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [VALUE_BITS-1:0]                      out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DEPTH-1:0]                           out_index,
  output logic                                       out_last,
  output logic                                       dbg_state
);

  localparam int SIZE = 1 << DEPTH;

  // First and final index of a vector depend on the emit direction.
  localparam logic [DEPTH-1:0] IDX_FIRST = (REVERSE != 0) ? DEPTH'(SIZE - 1) : '0;
  localparam logic [DEPTH-1:0] IDX_LAST  = (REVERSE != 0) ? '0 : DEPTH'(SIZE - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                                state_q;
  logic [DEPTH-1:0]                      idx_q;
  logic [SIZE-1:0][VALUE_BITS-1:0]       buf_q;

  logic accept;
  logic xfer;
  logic last_beat;

  // Beat / accept qualifiers shared by the FSM, the buffer and in_ready.
  always_comb begin
    last_beat = (idx_q == IDX_LAST);
    xfer      = out_valid && out_ready;
    in_ready  = !rst && ((state_q == IDLE) || (xfer && last_beat));
    accept    = in_valid && in_ready;
  end

  // Output mapping straight from the index and buffer registers.
  always_comb begin
    out_valid = (state_q == STREAM);
    out_index = idx_q;
    out_last  = last_beat;
    out_data  = buf_q[idx_q];
    dbg_state = state_q;
  end

  // Control FSM: state and beat index, reset asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= STREAM;
            idx_q   <= IDX_FIRST;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last_beat) begin
              // A new vector taken in this same cycle restarts the stream
              // with no bubble; otherwise fall back to IDLE.
              if (accept) begin
                state_q <= STREAM;
                idx_q   <= IDX_FIRST;
              end else begin
                state_q <= IDLE;
              end
            end else if (REVERSE != 0) begin
              idx_q <= idx_q - DEPTH'(1);
            end else begin
              idx_q <= idx_q + DEPTH'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Data buffer captures the whole vector on accept; it carries no reset
  // because its contents are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q <= in;
    end
  end

endmodule

// File: tb/tb_sort_serializer.sv
// tb_sort_serializer
// Directed, table-driven bench for sort_serializer with VALUE_BITS=8,
// DEPTH=2. Two instances share all stimulus: one forward, one REVERSE=1.
module tb_sort_serializer;

  localparam int VB = 8;
  localparam int DP = 2;
  localparam int SZ = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [SZ-1:0][VB-1:0] in_vec;
  logic                  in_valid;
  logic                  out_ready;

  logic          f_in_ready, f_out_valid, f_out_last, f_dbg;
  logic [VB-1:0] f_out_data;
  logic [DP-1:0] f_out_index;

  logic          r_in_ready, r_out_valid, r_out_last, r_dbg;
  logic [VB-1:0] r_out_data;
  logic [DP-1:0] r_out_index;

  sort_serializer #(.VALUE_BITS(VB), .DEPTH(DP), .REVERSE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_vec),
    .in_valid  (in_valid),
    .in_ready  (f_in_ready),
    .out_data  (f_out_data),
    .out_valid (f_out_valid),
    .out_ready (out_ready),
    .out_index (f_out_index),
    .out_last  (f_out_last),
    .dbg_state (f_dbg)
  );

  sort_serializer #(.VALUE_BITS(VB), .DEPTH(DP), .REVERSE(1)) dut_r (
    .clk       (clk),
    .rst       (rst),
    .in        (in_vec),
    .in_valid  (in_valid),
    .in_ready  (r_in_ready),
    .out_data  (r_out_data),
    .out_valid (r_out_valid),
    .out_ready (out_ready),
    .out_index (r_out_index),
    .out_last  (r_out_last),
    .dbg_state (r_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One record per cycle: inputs driven, then outputs expected from both
  // instances. Data/index/last are only compared when valid is expected.
  typedef struct {
    logic [SZ-1:0][VB-1:0] vin;
    logic                  vld;
    logic                  rdy;
    logic                  e_ir;
    logic                  e_ov;
    logic [VB-1:0]         f_d;
    logic [DP-1:0]         f_ix;
    logic                  f_l;
    logic [VB-1:0]         r_d;
    logic [DP-1:0]         r_ix;
    logic                  r_l;
  } vec_t;

  vec_t tbl[$];

  localparam logic [SZ-1:0][VB-1:0] V1 = {8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [SZ-1:0][VB-1:0] V2 = {8'h88, 8'h77, 8'h66, 8'h55};
  localparam logic [SZ-1:0][VB-1:0] V3 = {8'h04, 8'h03, 8'h02, 8'h01};
  localparam logic [SZ-1:0][VB-1:0] VF = {8'hFF, 8'hFF, 8'hFF, 8'hFF};

  // ---------------- driver tasks ----------------
  task automatic add(input logic [SZ-1:0][VB-1:0] vin, input logic vld, input logic rdy,
                     input logic e_ir, input logic e_ov,
                     input logic [VB-1:0] f_d, input logic [DP-1:0] f_ix, input logic f_l,
                     input logic [VB-1:0] r_d, input logic [DP-1:0] r_ix, input logic r_l);
    vec_t v;
    v.vin = vin; v.vld = vld; v.rdy = rdy; v.e_ir = e_ir; v.e_ov = e_ov;
    v.f_d = f_d; v.f_ix = f_ix; v.f_l = f_l;
    v.r_d = r_d; v.r_ix = r_ix; v.r_l = r_l;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_vec    = tbl[i].vin;
      in_valid  = tbl[i].vld;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("%s[%0d] f_in_ready", tag, i), 32'(f_in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("%s[%0d] r_in_ready", tag, i), 32'(r_in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("%s[%0d] f_out_valid", tag, i), 32'(f_out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("%s[%0d] r_out_valid", tag, i), 32'(r_out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("%s[%0d] f_out_data", tag, i), 32'(f_out_data), 32'(tbl[i].f_d));
        chk($sformatf("%s[%0d] f_out_index", tag, i), 32'(f_out_index), 32'(tbl[i].f_ix));
        chk($sformatf("%s[%0d] f_out_last", tag, i), 32'(f_out_last), 32'(tbl[i].f_l));
        chk($sformatf("%s[%0d] r_out_data", tag, i), 32'(r_out_data), 32'(tbl[i].r_d));
        chk($sformatf("%s[%0d] r_out_index", tag, i), 32'(r_out_index), 32'(tbl[i].r_ix));
        chk($sformatf("%s[%0d] r_out_last", tag, i), 32'(r_out_last), 32'(tbl[i].r_l));
      end
    end
    tbl.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    in_vec    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state, observed while rst is still high.
    #1;
    chk("rst f_out_valid", 32'(f_out_valid), 32'd0);
    chk("rst f_in_ready", 32'(f_in_ready), 32'd0);
    chk("rst f_out_index", 32'(f_out_index), 32'd0);
    chk("rst f_out_last", 32'(f_out_last), 32'd0);
    chk("rst r_out_last", 32'(r_out_last), 32'd1);
    chk("rst f_state", 32'(f_dbg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst f_in_ready", 32'(f_in_ready), 32'd1);

    // Basic stream.
    add(V1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add('0, 0, 1, 0, 1, 8'h11, 0, 0, 8'h44, 3, 0);
    add('0, 0, 1, 0, 1, 8'h22, 1, 0, 8'h33, 2, 0);
    add('0, 0, 1, 0, 1, 8'h33, 2, 0, 8'h22, 1, 0);
    add('0, 0, 1, 1, 1, 8'h44, 3, 1, 8'h11, 0, 1);
    add('0, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    run_table("basic");

    // Backpressure: out_ready 1,0,0,1,1,0,1.
    add(V1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add('0, 0, 1, 0, 1, 8'h11, 0, 0, 8'h44, 3, 0);
    add('0, 0, 0, 0, 1, 8'h22, 1, 0, 8'h33, 2, 0);
    add('0, 0, 0, 0, 1, 8'h22, 1, 0, 8'h33, 2, 0);
    add('0, 0, 1, 0, 1, 8'h22, 1, 0, 8'h33, 2, 0);
    add('0, 0, 1, 0, 1, 8'h33, 2, 0, 8'h22, 1, 0);
    add('0, 0, 0, 0, 1, 8'h44, 3, 1, 8'h11, 0, 1);
    add('0, 0, 1, 1, 1, 8'h44, 3, 1, 8'h11, 0, 1);
    add('0, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    run_table("bp");

    // Back-to-back: V2 held valid while V1 streams, taken on V1's last beat.
    add(V1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(V2, 1, 1, 0, 1, 8'h11, 0, 0, 8'h44, 3, 0);
    add(V2, 1, 1, 0, 1, 8'h22, 1, 0, 8'h33, 2, 0);
    add(V2, 1, 1, 0, 1, 8'h33, 2, 0, 8'h22, 1, 0);
    add(V2, 1, 1, 1, 1, 8'h44, 3, 1, 8'h11, 0, 1);
    add('0, 0, 1, 0, 1, 8'h55, 0, 0, 8'h88, 3, 0);
    add('0, 0, 1, 0, 1, 8'h66, 1, 0, 8'h77, 2, 0);
    add('0, 0, 1, 0, 1, 8'h77, 2, 0, 8'h66, 1, 0);
    add('0, 0, 1, 1, 1, 8'h88, 3, 1, 8'h55, 0, 1);
    add('0, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    run_table("b2b");

    // Input isolation: lanes forced to 0xFF while streaming.
    add(V1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(VF, 0, 1, 0, 1, 8'h11, 0, 0, 8'h44, 3, 0);
    add(VF, 0, 0, 0, 1, 8'h22, 1, 0, 8'h33, 2, 0);
    add(VF, 0, 1, 0, 1, 8'h22, 1, 0, 8'h33, 2, 0);
    add(VF, 0, 1, 0, 1, 8'h33, 2, 0, 8'h22, 1, 0);
    add(VF, 0, 1, 1, 1, 8'h44, 3, 1, 8'h11, 0, 1);
    add('0, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    run_table("iso");

    // Reset mid-stream after 0x11 and 0x22 have transferred.
    add(V1, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add('0, 0, 1, 0, 1, 8'h11, 0, 0, 8'h44, 3, 0);
    add('0, 0, 1, 0, 1, 8'h22, 1, 0, 8'h33, 2, 0);
    run_table("pre-rst");
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("mid f_out_data", 32'(f_out_data), 32'h33);
    rst = 1'b1;
    #1;
    chk("async f_out_valid", 32'(f_out_valid), 32'd0);
    chk("async r_out_valid", 32'(r_out_valid), 32'd0);
    chk("async f_in_ready", 32'(f_in_ready), 32'd0);
    chk("async f_out_index", 32'(f_out_index), 32'd0);
    chk("async r_out_index", 32'(r_out_index), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel f_in_ready", 32'(f_in_ready), 32'd1);
    chk("rel r_in_ready", 32'(r_in_ready), 32'd1);
    chk("rel f_out_valid", 32'(f_out_valid), 32'd0);

    add(V3, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add('0, 0, 1, 0, 1, 8'h01, 0, 0, 8'h04, 3, 0);
    add('0, 0, 1, 0, 1, 8'h02, 1, 0, 8'h03, 2, 0);
    add('0, 0, 1, 0, 1, 8'h03, 2, 0, 8'h02, 1, 0);
    add('0, 0, 1, 1, 1, 8'h04, 3, 1, 8'h01, 0, 1);
    add('0, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    run_table("post-rst");

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sort_serializer.md
SORT_SERIALIZER -- requirements
Module: sort_serializer

Interface
REQ-001 The block SHALL have parameter VALUE_BITS, default 32, giving the width of one element.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving log2 of the vector size; SIZE = 1 << DEPTH is derived and not overridable.
REQ-003 The block SHALL have parameter REVERSE, default 0; 0 emits index 0 first, 1 emits index SIZE-1 first.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 in  in  [SIZE-1:0][VALUE_BITS-1:0]  parallel sorted vector from the sorter output.
REQ-007 in_valid  in  1  the in vector is valid this cycle.
REQ-008 in_ready  out  1  the block accepts the in vector this cycle.
REQ-009 out_data  out  VALUE_BITS  current element of the streamed vector.
REQ-010 out_valid  out  1  out_data, out_index and out_last are valid.
REQ-011 out_ready  in  1  the downstream consumer takes the current beat.
REQ-012 out_index  out  DEPTH  vector index of the current beat.
REQ-013 out_last  out  1  the current beat is the final beat of the vector.

Function
REQ-014 Accept occurs when in_valid && in_ready; beat transfer occurs when out_valid && out_ready.
REQ-015 FSM states SHALL be IDLE and STREAM.
- IDLE -> STREAM on accept.
- STREAM -> IDLE on transfer of the last beat with no simultaneous accept.
- STREAM -> STREAM on transfer of the last beat with simultaneous accept.
REQ-016 in_ready SHALL equal (state==IDLE) || (out_valid && out_ready && out_last), gated to 0 while rst is high.
REQ-017 On accept, all SIZE elements SHALL be registered into an internal buffer in one cycle; the idx register SHALL load 0, or SIZE-1 when REVERSE=1.
REQ-018 out_valid SHALL be 1 in STREAM and 0 in IDLE; the first beat SHALL appear in the cycle after accept, giving a latency of 1.
REQ-019 Output mapping:
- out_data SHALL equal buffer[idx].
- out_index SHALL equal idx.
- out_last SHALL be 1 when idx is SIZE-1 (REVERSE=0) or 0 (REVERSE=1).
REQ-020 On a non-last transfer, idx SHALL step by +1 (REVERSE=0) or -1 (REVERSE=1); idx SHALL never wrap within a vector.
REQ-021 While out_valid && !out_ready, out_data, out_index and out_last SHALL hold stable; no beat is dropped or duplicated.
REQ-022 Changes on in or in_valid while in STREAM, except in the last-beat accept cycle, SHALL have no effect on the buffer or the outputs.
REQ-023 Back-to-back vectors SHALL stream with zero bubble cycles when in_valid and out_ready are held high: SIZE beats in SIZE cycles per vector.
REQ-024 out_ready without out_valid SHALL be ignored; in_valid while in_ready=0 SHALL be held off by the upstream stage and is not captured.

Reset
REQ-025 While rst is high: state=IDLE, idx=0, out_valid=0, in_ready=0; out_index and out_last follow idx; these take effect immediately, independent of clk.
REQ-026 The data buffer SHALL NOT be reset; out_data is undefined while out_valid=0.
REQ-027 Reset asserted mid-stream SHALL abandon the partial vector; after deassertion in_ready=1 and the next accepted vector SHALL start from its first index.

Verification (bench parameters: VALUE_BITS=8, DEPTH=2, SIZE=4)
REQ-028 Basic stream:
- Stimulus: reset, then accept in={0x44,0x33,0x22,0x11} (index 3..0), out_ready=1.
- Response: out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after accept; out_index 0..3; out_last only on 0x44; then out_valid=0.
REQ-029 Backpressure:
- Stimulus: same vector, out_ready pattern 1,0,0,1,1,0,1.
- Response: out_data held during the 0 cycles; exactly 0x11,0x22,0x33,0x44 delivered once each.
REQ-030 Back-to-back:
- Stimulus: second vector {0x88,0x77,0x66,0x55} with in_valid held high.
- Response: second vector accepted in the cycle 0x44 transfers; 0x55 follows the next cycle; 8 beats in 8 cycles; out_last on 0x44 and 0x88.
REQ-031 REVERSE=1, first vector.
- Response: 0x44,0x33,0x22,0x11; out_index 3,2,1,0; out_last on 0x11.
REQ-032 Reset mid-stream:
- Stimulus: assert rst asynchronously after 0x11,0x22 have transferred.
- Response: out_valid=0 before the next clock edge; after deassertion in_ready=1; a new vector {0x04,0x03,0x02,0x01} streams 0x01..0x04 from out_index 0.
REQ-033 Input isolation:
- Stimulus: drive in to 0xFF in all lanes during STREAM with in_ready=0.
- Response: streamed beats unchanged.
